// File: rtl/lockstep_mode_ctrl_if.sv
// Core-side memory handshake bundle watched by lockstep_mode_ctrl.
// The master modport drives the cores' req/gnt/rvalid/address traffic.
// The slave modport is the read-only view used by the mode controller.
interface lockstep_mode_ctrl_if #(
    parameter int N_CORES = 8,
    parameter int ADDR_W  = 32
);

    logic [N_CORES-1:0]        req_i;
    logic [N_CORES-1:0]        gnt_i;
    logic [N_CORES-1:0]        rvalid_i;
    logic [N_CORES*ADDR_W-1:0] addr_i;

    modport master (
        output req_i,
        output gnt_i,
        output rvalid_i,
        output addr_i
    );

    modport slave (
        input  req_i,
        input  gnt_i,
        input  rvalid_i,
        input  addr_i
    );

endinterface

// File: rtl/lockstep_mode_ctrl.sv
// lockstep_mode_ctrl: sequences entry into and exit from core lockstep mode.
// New requests are halted, per-core outstanding transactions are drained,
// and the registered lockstep mode flips only once every core is idle.
// In lockstep mode it also produces the same-address broadcast qualifier.
//
// Optional feature macro: LOCKSTEP_TIMEOUT_EN
//   When defined, a drain that does not finish within TIMEOUT cycles is
//   aborted back to the previous mode and err_o[1] is raised.
//   When undefined, drains wait indefinitely and err_o[1] is always 0.
module lockstep_mode_ctrl #(
    parameter int N_CORES = 8,
    parameter int ADDR_W  = 32,
    parameter int OUTST_W = 2,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enter_req_i,
    input  logic                 exit_req_i,
    input  logic                 err_clr_i,
    lockstep_mode_ctrl_if.slave  bus,
    output logic [N_CORES-1:0]   halt_o,
    output logic                 lockstep_mode_o,
    output logic                 same_address_o,
    output logic                 done_o,
    output logic [1:0]           state_o,
    output logic [1:0]           err_o
);

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        DRAIN_IN  = 2'd1,
        LOCKSTEP  = 2'd2,
        DRAIN_OUT = 2'd3
    } state_e;

    localparam logic [OUTST_W-1:0] CNT_MAX = {OUTST_W{1'b1}};

    state_e               r_state;
    state_e               w_stateNext;

    logic [OUTST_W-1:0]   r_cnt     [N_CORES];
    logic [OUTST_W-1:0]   w_cntNext [N_CORES];
    logic [N_CORES-1:0]   w_grant;
    logic [N_CORES-1:0]   w_cntErr;
    logic [N_CORES-1:0]   w_idle;
    logic                 w_allIdle;

    logic                 w_inDrain;
    logic                 w_timeout;
    logic                 w_abort;

    logic [N_CORES-1:0]   r_halt;
    logic                 r_lockstep;
    logic                 r_done;
    logic [1:0]           r_err;

    logic [N_CORES-1:0]   w_haltNext;
    logic                 w_lockstepNext;
    logic                 w_doneNext;
    logic [1:0]           w_errEvent;

    logic                 w_addrEq;

    assign w_grant   = bus.req_i & bus.gnt_i;
    assign w_inDrain = (r_state == DRAIN_IN) || (r_state == DRAIN_OUT);

    // Per-core outstanding counter update, error detection and idle status.
    // A response retiring the last transaction this cycle already lets the
    // core count as idle, so the mode switch is not delayed by a cycle.
    // A core with req_i still high is never idle, even without a grant yet.
    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            w_cntNext[i] = r_cnt[i];
            w_cntErr[i]  = 1'b0;
            case ({w_grant[i], bus.rvalid_i[i]})
                2'b10: begin
                    if (r_cnt[i] == CNT_MAX) begin
                        w_cntErr[i] = 1'b1;
                    end else begin
                        w_cntNext[i] = r_cnt[i] + 1'b1;
                    end
                end
                2'b01: begin
                    if (r_cnt[i] == '0) begin
                        w_cntErr[i] = 1'b1;
                    end else begin
                        w_cntNext[i] = r_cnt[i] - 1'b1;
                    end
                end
                default: begin
                    w_cntNext[i] = r_cnt[i];
                end
            endcase
            w_idle[i] = (w_cntNext[i] == '0) & ~bus.req_i[i];
        end
    end

    assign w_allIdle = &w_idle;

    // Outstanding transaction counters, one per core.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_CORES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                r_cnt[i] <= w_cntNext[i];
            end
        end
    end

`ifdef LOCKSTEP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmoCnt;

    // Drain cycle counter: zero outside the drain states, so it starts from
    // zero on every drain entry, and counts each drain cycle up to TIMEOUT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmoCnt <= '0;
        end else if (!w_inDrain) begin
            r_tmoCnt <= '0;
        end else if (r_tmoCnt != TMO_W'(TIMEOUT)) begin
            r_tmoCnt <= r_tmoCnt + 1'b1;
        end
    end

    assign w_timeout = w_inDrain && (r_tmoCnt == TMO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= NORMAL;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // FSM next-state logic; completing the drain takes priority over a
    // timeout landing in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_abort     = 1'b0;
        case (r_state)
            NORMAL: begin
                if (enter_req_i) begin
                    w_stateNext = DRAIN_IN;
                end
            end
            DRAIN_IN: begin
                if (w_allIdle) begin
                    w_stateNext = LOCKSTEP;
                end else if (w_timeout) begin
                    w_stateNext = NORMAL;
                    w_abort     = 1'b1;
                end
            end
            LOCKSTEP: begin
                if (exit_req_i) begin
                    w_stateNext = DRAIN_OUT;
                end
            end
            DRAIN_OUT: begin
                if (w_allIdle) begin
                    w_stateNext = NORMAL;
                end else if (w_timeout) begin
                    w_stateNext = LOCKSTEP;
                    w_abort     = 1'b1;
                end
            end
            default: begin
                w_stateNext = NORMAL;
            end
        endcase
    end

    // FSM output decode from the next state, so the registered outputs line
    // up with the first cycle of each state. done only marks a completed
    // drain; an aborted drain never reaches these two transitions.
    always_comb begin
        w_haltNext     = '0;
        w_lockstepNext = 1'b0;
        w_doneNext     = 1'b0;
        if ((w_stateNext == DRAIN_IN) || (w_stateNext == DRAIN_OUT)) begin
            w_haltNext = '1;
        end
        if ((w_stateNext == LOCKSTEP) || (w_stateNext == DRAIN_OUT)) begin
            w_lockstepNext = 1'b1;
        end
        if (((r_state == DRAIN_IN)  && (w_stateNext == LOCKSTEP)) ||
            ((r_state == DRAIN_OUT) && (w_stateNext == NORMAL))) begin
            w_doneNext = 1'b1;
        end
    end

    // Registered halt, lockstep mode and done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_halt     <= '0;
            r_lockstep <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_halt     <= w_haltNext;
            r_lockstep <= w_lockstepNext;
            r_done     <= w_doneNext;
        end
    end

    assign w_errEvent = {w_abort, |w_cntErr};

    // Sticky error flags; a fresh event wins over a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 2'b00;
        end else begin
            r_err <= (err_clr_i ? 2'b00 : r_err) | w_errEvent;
        end
    end

    // Compare every core address against core 0 for the broadcast qualifier.
    always_comb begin
        w_addrEq = 1'b1;
        for (int i = 1; i < N_CORES; i++) begin
            if (bus.addr_i[i*ADDR_W +: ADDR_W] != bus.addr_i[0 +: ADDR_W]) begin
                w_addrEq = 1'b0;
            end
        end
    end

    assign same_address_o  = r_lockstep & (&bus.req_i) & w_addrEq;
    assign halt_o          = r_halt;
    assign lockstep_mode_o = r_lockstep;
    assign done_o          = r_done;
    assign state_o         = r_state;
    assign err_o           = r_err;

endmodule

// File: tb/tb_lockstep_mode_ctrl.sv
// Self-checking bench for lockstep_mode_ctrl.
// Each applied cycle pushes the expected post-edge outputs to a scoreboard
// queue; after the clock edge the entry is popped and compared.
`timescale 1ns/1ps
module tb_lockstep_mode_ctrl;

    localparam int N_CORES = 8;
    localparam int ADDR_W  = 32;
    localparam int OUTST_W = 2;
    localparam int TIMEOUT = 16;

    localparam logic [1:0] S_NORM = 2'd0;
    localparam logic [1:0] S_DIN  = 2'd1;
    localparam logic [1:0] S_LCK  = 2'd2;
    localparam logic [1:0] S_DOUT = 2'd3;

    typedef struct {
        string      tag;
        logic [1:0] state;
        logic [7:0] halt;
        logic       lock;
        logic       done;
        logic [1:0] err;
    } exp_t;

    logic        clock = 1'b0;
    logic        rstN;
    logic        enterReq;
    logic        exitReq;
    logic        errClr;
    logic [7:0]  haltOut;
    logic        lockOut;
    logic        sameOut;
    logic        doneOut;
    logic [1:0]  stateOut;
    logic [1:0]  errOut;

    exp_t        expQ[$];
    int          vectorCount = 0;
    int          missCount   = 0;

    lockstep_mode_ctrl_if #(.N_CORES(N_CORES), .ADDR_W(ADDR_W)) bus ();

    lockstep_mode_ctrl #(
        .N_CORES (N_CORES),
        .ADDR_W  (ADDR_W),
        .OUTST_W (OUTST_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i           (clock),
        .rst_ni          (rstN),
        .enter_req_i     (enterReq),
        .exit_req_i      (exitReq),
        .err_clr_i       (errClr),
        .bus             (bus),
        .halt_o          (haltOut),
        .lockstep_mode_o (lockOut),
        .same_address_o  (sameOut),
        .done_o          (doneOut),
        .state_o         (stateOut),
        .err_o           (errOut)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    // Count one comparison and report it when the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus, queue the outputs expected after the
    // edge, then pop that entry and compare it against the DUT.
    task automatic applyStimulus(input string tag, input logic en, input logic ex,
                                 input logic [7:0] req, input logic [7:0] gnt,
                                 input logic [7:0] rv, input logic clr,
                                 input logic [1:0] eState, input logic [7:0] eHalt,
                                 input logic eLock, input logic eDone,
                                 input logic [1:0] eErr);
        exp_t e;
        @(negedge clock);
        enterReq     = en;
        exitReq      = ex;
        bus.req_i    = req;
        bus.gnt_i    = gnt;
        bus.rvalid_i = rv;
        errClr       = clr;
        e.tag   = tag;
        e.state = eState;
        e.halt  = eHalt;
        e.lock  = eLock;
        e.done  = eDone;
        e.err   = eErr;
        expQ.push_back(e);
        @(posedge clock);
        #1;
        e = expQ.pop_front();
        checkOutput({e.tag, ".state"}, 32'(stateOut), 32'(e.state));
        checkOutput({e.tag, ".halt"},  32'(haltOut),  32'(e.halt));
        checkOutput({e.tag, ".lock"},  32'(lockOut),  32'(e.lock));
        checkOutput({e.tag, ".done"},  32'(doneOut),  32'(e.done));
        checkOutput({e.tag, ".err"},   32'(errOut),   32'(e.err));
    endtask

    // Apply an idle cycle with only the given expectation.
    task automatic idleCycle(input string tag, input logic [1:0] eState,
                             input logic [7:0] eHalt, input logic eLock,
                             input logic eDone, input logic [1:0] eErr);
        applyStimulus(tag, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      eState, eHalt, eLock, eDone, eErr);
    endtask

    // Put the same address on every core.
    task automatic setAllAddr(input logic [31:0] a);
        for (int i = 0; i < N_CORES; i++) begin
            bus.addr_i[i*ADDR_W +: ADDR_W] = a;
        end
    endtask

    // Main test sequence.
    initial begin
        rstN         = 1'b0;
        enterReq     = 1'b0;
        exitReq      = 1'b0;
        errClr       = 1'b0;
        bus.req_i    = '0;
        bus.gnt_i    = '0;
        bus.rvalid_i = '0;
        setAllAddr(32'h0);

        #12;
        checkOutput("rst.state", 32'(stateOut), 32'(S_NORM));
        checkOutput("rst.halt",  32'(haltOut),  32'h0);
        checkOutput("rst.lock",  32'(lockOut),  32'h0);
        checkOutput("rst.done",  32'(doneOut),  32'h0);
        checkOutput("rst.err",   32'(errOut),   32'h0);
        @(negedge clock);
        rstN = 1'b1;

        // Minimum-latency entry with idle cores.
        applyStimulus("t1Enter", 1, 0, 8'h00, 8'h00, 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        idleCycle("t1Lock", S_LCK, 8'h00, 1, 1, 2'b00);
        idleCycle("t1Hold", S_LCK, 8'h00, 1, 0, 2'b00);

        // Same-address qualifier in lockstep mode.
        @(negedge clock);
        setAllAddr(32'h1000_0040);
        bus.req_i = 8'hFF;
        #1;
        checkOutput("sameAll", 32'(sameOut), 32'h1);
        bus.addr_i[7*ADDR_W +: ADDR_W] = 32'h1000_0044;
        #1;
        checkOutput("sameCore7Diff", 32'(sameOut), 32'h0);
        setAllAddr(32'h1000_0040);
        bus.req_i = 8'h7F;
        #1;
        checkOutput("sameReq7F", 32'(sameOut), 32'h0);

        applyStimulus("lckIgnEnter", 1, 0, 8'h00, 8'h00, 8'h00, 0, S_LCK, 8'h00, 1, 0, 2'b00);
        applyStimulus("t1Exit", 0, 1, 8'h00, 8'h00, 8'h00, 0, S_DOUT, 8'hFF, 1, 0, 2'b00);
        idleCycle("t1Normal", S_NORM, 8'h00, 0, 1, 2'b00);
        idleCycle("normIdle", S_NORM, 8'h00, 0, 0, 2'b00);
        applyStimulus("normIgnExit", 0, 1, 8'h00, 8'h00, 8'h00, 0, S_NORM, 8'h00, 0, 0, 2'b00);

        // Core 3 holds two outstanding transactions across the drain.
        applyStimulus("t2Gnt0", 0, 0, 8'h08, 8'h08, 8'h00, 0, S_NORM, 8'h00, 0, 0, 2'b00);
        applyStimulus("t2Gnt1", 0, 0, 8'h08, 8'h08, 8'h00, 0, S_NORM, 8'h00, 0, 0, 2'b00);
        applyStimulus("t2EnterWins", 1, 1, 8'h00, 8'h00, 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        for (int c = 1; c <= 8; c++) begin
            applyStimulus($sformatf("t2Drain%0d", c), 0, 0, 8'h00, 8'h00,
                          (c == 5) ? 8'h08 : 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        end
        applyStimulus("t2LastRv", 0, 0, 8'h00, 8'h00, 8'h08, 0, S_LCK, 8'h00, 1, 1, 2'b00);
        applyStimulus("t2Exit", 0, 1, 8'h00, 8'h00, 8'h00, 0, S_DOUT, 8'hFF, 1, 0, 2'b00);
        idleCycle("t2Normal", S_NORM, 8'h00, 0, 1, 2'b00);

        // Core 5 raises a request during DRAIN_IN and is granted late.
        applyStimulus("t3Enter", 1, 0, 8'h00, 8'h00, 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus($sformatf("t3Req%0d", c), 0, 0, 8'h20, 8'h00, 8'h00, 0,
                          S_DIN, 8'hFF, 0, 0, 2'b00);
        end
        applyStimulus("t3Gnt", 0, 0, 8'h20, 8'h20, 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        applyStimulus("t3IgnExit", 0, 1, 8'h00, 8'h00, 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        applyStimulus("t3Rv", 0, 0, 8'h00, 8'h00, 8'h20, 0, S_LCK, 8'h00, 1, 1, 2'b00);

        // Exit drain waits on core 1 granted in the exit cycle.
        applyStimulus("doExit", 0, 1, 8'h02, 8'h02, 8'h00, 0, S_DOUT, 8'hFF, 1, 0, 2'b00);
        applyStimulus("doIgnReq", 1, 1, 8'h00, 8'h00, 8'h00, 0, S_DOUT, 8'hFF, 1, 0, 2'b00);
        applyStimulus("doRv", 0, 0, 8'h00, 8'h00, 8'h02, 0, S_NORM, 8'h00, 0, 1, 2'b00);

        // Underflow error, stickiness, clear, and event beating clear.
        applyStimulus("udfRv", 0, 0, 8'h00, 8'h00, 8'h04, 0, S_NORM, 8'h00, 0, 0, 2'b01);
        idleCycle("udfSticky", S_NORM, 8'h00, 0, 0, 2'b01);
        applyStimulus("udfClr", 0, 0, 8'h00, 8'h00, 8'h00, 1, S_NORM, 8'h00, 0, 0, 2'b00);
        applyStimulus("udfClrWin", 0, 0, 8'h00, 8'h00, 8'h04, 1, S_NORM, 8'h00, 0, 0, 2'b01);
        applyStimulus("udfClr2", 0, 0, 8'h00, 8'h00, 8'h00, 1, S_NORM, 8'h00, 0, 0, 2'b00);

        // Overflow saturates at 3 outstanding and raises err_o[0].
        for (int c = 0; c < 3; c++) begin
            applyStimulus($sformatf("ovfGnt%0d", c), 0, 0, 8'h01, 8'h01, 8'h00, 0,
                          S_NORM, 8'h00, 0, 0, 2'b00);
        end
        applyStimulus("ovfSat", 0, 0, 8'h01, 8'h01, 8'h00, 0, S_NORM, 8'h00, 0, 0, 2'b01);
        applyStimulus("ovfClrRv", 0, 0, 8'h00, 8'h00, 8'h01, 1, S_NORM, 8'h00, 0, 0, 2'b00);
        applyStimulus("ovfRv1", 0, 0, 8'h00, 8'h00, 8'h01, 0, S_NORM, 8'h00, 0, 0, 2'b00);
        applyStimulus("ovfRv2", 0, 0, 8'h00, 8'h00, 8'h01, 0, S_NORM, 8'h00, 0, 0, 2'b00);
        applyStimulus("ovfEnter", 1, 0, 8'h00, 8'h00, 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        idleCycle("ovfLock", S_LCK, 8'h00, 1, 1, 2'b00);
        applyStimulus("ovfExit", 0, 1, 8'h00, 8'h00, 8'h00, 0, S_DOUT, 8'hFF, 1, 0, 2'b00);
        idleCycle("ovfNormal", S_NORM, 8'h00, 0, 1, 2'b00);

        // Asynchronous reset in the middle of a drain.
        applyStimulus("rdGnt", 0, 0, 8'h01, 8'h01, 8'h00, 0, S_NORM, 8'h00, 0, 0, 2'b00);
        applyStimulus("rdEnter", 1, 0, 8'h00, 8'h00, 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        idleCycle("rdWait", S_DIN, 8'hFF, 0, 0, 2'b00);
        @(negedge clock);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rdAsync.state", 32'(stateOut), 32'(S_NORM));
        checkOutput("rdAsync.halt",  32'(haltOut),  32'h0);
        @(negedge clock);
        rstN = 1'b1;
        applyStimulus("rdEnter2", 1, 0, 8'h00, 8'h00, 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        idleCycle("rdLock", S_LCK, 8'h00, 1, 1, 2'b00);
        applyStimulus("rdExit", 0, 1, 8'h00, 8'h00, 8'h00, 0, S_DOUT, 8'hFF, 1, 0, 2'b00);
        idleCycle("rdNormal", S_NORM, 8'h00, 0, 1, 2'b00);

`ifdef LOCKSTEP_TIMEOUT_EN
        // Core 0 never answers: DRAIN_IN aborts after TIMEOUT cycles.
        applyStimulus("toGnt", 0, 0, 8'h01, 8'h01, 8'h00, 0, S_NORM, 8'h00, 0, 0, 2'b00);
        applyStimulus("toEnter", 1, 0, 8'h00, 8'h00, 8'h00, 0, S_DIN, 8'hFF, 0, 0, 2'b00);
        for (int c = 1; c < TIMEOUT; c++) begin
            idleCycle($sformatf("toWait%0d", c), S_DIN, 8'hFF, 0, 0, 2'b00);
        end
        idleCycle("toAbort", S_NORM, 8'h00, 0, 0, 2'b10);
        idleCycle("toSticky", S_NORM, 8'h00, 0, 0, 2'b10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
